// File: rtl/wb_retire_queue.sv
// wb_retire_queue: DEPTH-entry in-order retire queue for the writeback stage.
// Entries from MEM are pushed at the tail. At most one entry retires per cycle
// from the head. Retiring writes the GPR file, drives the external CSR unit,
// and raises exception / ERTN flushes.
// Optional build macro WB_PERF_CNT_EN adds retire_cnt / flush_cnt counters.
module wb_retire_queue #(
  parameter int DEPTH     = 2,
  parameter int DATA_W    = 32,
  parameter int CSR_NUM_W = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ms_to_ws_valid,
  output logic                 ws_allowin,
  input  logic [31:0]          ms_pc,
  input  logic                 ms_gr_we,
  input  logic [4:0]           ms_dest,
  input  logic [DATA_W-1:0]    ms_result,
  input  logic                 ms_csr_re,
  input  logic                 ms_csr_we,
  input  logic [CSR_NUM_W-1:0] ms_csr_num,
  input  logic [DATA_W-1:0]    ms_csr_wmask,
  input  logic [DATA_W-1:0]    ms_csr_wvalue,
  input  logic                 ms_ex,
  input  logic [5:0]           ms_ecode,
  input  logic                 ms_ertn,
  input  logic                 ws_stall,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 ws_csr_hazard,
  output logic                 csr_re,
  output logic [CSR_NUM_W-1:0] csr_num,
  input  logic [DATA_W-1:0]    csr_rvalue,
  output logic                 csr_we,
  output logic [DATA_W-1:0]    csr_wmask,
  output logic [DATA_W-1:0]    csr_wvalue,
  output logic                 wb_ex,
  output logic [5:0]           wb_ecode,
  output logic [8:0]           wb_esubcode,
  output logic                 eret_flush,
  output logic [31:0]          wb_pc,
  output logic                 ws_flush_pipe,
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_wen,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [DATA_W-1:0]    debug_wb_rf_wdata
`ifdef WB_PERF_CNT_EN
  ,
  output logic [63:0]          retire_cnt,
  output logic [31:0]          flush_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // Entry storage, one array per field; contents are never reset.
  logic [31:0]          pc_mem     [DEPTH];
  logic                 gr_we_mem  [DEPTH];
  logic [4:0]           dest_mem   [DEPTH];
  logic [DATA_W-1:0]    result_mem [DEPTH];
  logic                 csr_re_mem [DEPTH];
  logic                 csr_we_mem [DEPTH];
  logic [CSR_NUM_W-1:0] csr_num_mem[DEPTH];
  logic [DATA_W-1:0]    wmask_mem  [DEPTH];
  logic [DATA_W-1:0]    wvalue_mem [DEPTH];
  logic                 ex_mem     [DEPTH];
  logic [5:0]           ecode_mem  [DEPTH];
  logic                 ertn_mem   [DEPTH];

  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic retire;
  logic push;
  logic head_ex;
  logic head_ertn;
  logic head_normal;
  logic [DEPTH-1:0] hazard_vec;

  assign retire      = (count_reg != '0) && !ws_stall;
  assign head_ex     = ex_mem[rd_ptr_reg];
  assign head_ertn   = ertn_mem[rd_ptr_reg];
  assign head_normal = !head_ex && !head_ertn;
  // Allowin looks only at the registered count, so a same-cycle pop never
  // frees a slot for a push when the queue is full.
  assign ws_allowin  = (count_reg != FULL_COUNT) && !ws_flush_pipe;
  assign push        = ms_to_ws_valid && ws_allowin;
  assign wb_esubcode = 9'd0;

  // Head-derived retire outputs, all gated by retire.
  always_comb begin
    rf_we         = 1'b0;
    rf_waddr      = '0;
    rf_wdata      = '0;
    csr_re        = 1'b0;
    csr_we        = 1'b0;
    csr_num       = '0;
    csr_wmask     = '0;
    csr_wvalue    = '0;
    wb_ex         = 1'b0;
    wb_ecode      = '0;
    eret_flush    = 1'b0;
    wb_pc         = '0;
    ws_flush_pipe = 1'b0;
    if (retire) begin
      wb_pc         = pc_mem[rd_ptr_reg];
      rf_waddr      = dest_mem[rd_ptr_reg];
      rf_wdata      = csr_re_mem[rd_ptr_reg] ? csr_rvalue : result_mem[rd_ptr_reg];
      csr_num       = csr_num_mem[rd_ptr_reg];
      csr_wmask     = wmask_mem[rd_ptr_reg];
      csr_wvalue    = wvalue_mem[rd_ptr_reg];
      wb_ex         = head_ex;
      wb_ecode      = head_ex ? ecode_mem[rd_ptr_reg] : 6'd0;
      // ERTN reads the return address from the CSR unit.
      eret_flush    = !head_ex && head_ertn;
      ws_flush_pipe = head_ex || head_ertn;
      rf_we         = head_normal && (gr_we_mem[rd_ptr_reg] || csr_re_mem[rd_ptr_reg]);
      csr_we        = head_normal && csr_we_mem[rd_ptr_reg];
      csr_re        = !head_ex && (head_ertn || csr_re_mem[rd_ptr_reg]);
    end
  end

  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  // Per-slot hazard: a slot is occupied when its distance from rd_ptr
  // (modulo DEPTH) is below count.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hazard
      logic [PTR_W-1:0] offset;
      assign offset         = PTR_W'(gi) - rd_ptr_reg;
      assign hazard_vec[gi] = csr_re_mem[gi] && (CNT_W'(offset) < count_reg);
    end
  endgenerate

  assign ws_csr_hazard = |hazard_vec;

  // Next pointer/count: a flush empties the queue and drops any push.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (ws_flush_pipe) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
      wr_ptr_next = rd_ptr_reg + 1'b1;
      count_next  = '0;
    end else begin
      if (retire) rd_ptr_next = rd_ptr_reg + 1'b1;
      if (push)   wr_ptr_next = wr_ptr_reg + 1'b1;
      if (push && !retire)      count_next = count_reg + 1'b1;
      else if (!push && retire) count_next = count_reg - 1'b1;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entry write at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]      <= ms_pc;
      gr_we_mem[wr_ptr_reg]   <= ms_gr_we;
      dest_mem[wr_ptr_reg]    <= ms_dest;
      result_mem[wr_ptr_reg]  <= ms_result;
      csr_re_mem[wr_ptr_reg]  <= ms_csr_re;
      csr_we_mem[wr_ptr_reg]  <= ms_csr_we;
      csr_num_mem[wr_ptr_reg] <= ms_csr_num;
      wmask_mem[wr_ptr_reg]   <= ms_csr_wmask;
      wvalue_mem[wr_ptr_reg]  <= ms_csr_wvalue;
      ex_mem[wr_ptr_reg]      <= ms_ex;
      ecode_mem[wr_ptr_reg]   <= ms_ecode;
      ertn_mem[wr_ptr_reg]    <= ms_ertn;
    end
  end

`ifdef WB_PERF_CNT_EN
  // Performance counters: non-exception retires and pipeline flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (retire && !head_ex) retire_cnt <= retire_cnt + 64'd1;
      if (ws_flush_pipe)      flush_cnt  <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_retire_queue.sv
// Self-checking bench for wb_retire_queue: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_wb_retire_queue;
  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] wmask;
    logic [31:0] wvalue;
    logic        ex;
    logic [5:0]  ecode;
    logic        ertn;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  logic ms_to_ws_valid, ws_allowin;
  logic [31:0] ms_pc;
  logic ms_gr_we;
  logic [4:0] ms_dest;
  logic [31:0] ms_result;
  logic ms_csr_re, ms_csr_we;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_csr_wmask, ms_csr_wvalue;
  logic ms_ex;
  logic [5:0] ms_ecode;
  logic ms_ertn, ws_stall;
  logic rf_we;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  logic ws_csr_hazard, csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic csr_we;
  logic [31:0] csr_wmask, csr_wvalue;
  logic wb_ex;
  logic [5:0] wb_ecode;
  logic [8:0] wb_esubcode;
  logic eret_flush;
  logic [31:0] wb_pc;
  logic ws_flush_pipe;
  logic [31:0] debug_wb_pc;
  logic [3:0] debug_wb_rf_wen;
  logic [4:0] debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`ifdef WB_PERF_CNT_EN
  logic [63:0] retire_cnt;
  logic [31:0] flush_cnt;
  logic [63:0] m_retire_cnt;
  logic [31:0] m_flush_cnt;
`endif

  wb_retire_queue #(.DEPTH(DEPTH), .DATA_W(32), .CSR_NUM_W(14)) dut (
    .clk(clk), .reset(reset),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result),
    .ms_csr_re(ms_csr_re), .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num),
    .ms_csr_wmask(ms_csr_wmask), .ms_csr_wvalue(ms_csr_wvalue),
    .ms_ex(ms_ex), .ms_ecode(ms_ecode), .ms_ertn(ms_ertn), .ws_stall(ws_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_csr_hazard(ws_csr_hazard), .csr_re(csr_re), .csr_num(csr_num),
    .csr_rvalue(csr_rvalue), .csr_we(csr_we), .csr_wmask(csr_wmask),
    .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .eret_flush(eret_flush), .wb_pc(wb_pc),
    .ws_flush_pipe(ws_flush_pipe), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
`ifdef WB_PERF_CNT_EN
    , .retire_cnt(retire_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  ent_t model_q[$];

  // Observed outputs of the most recent step, for directed checks.
  logic obs_allowin, obs_rf_we, obs_csr_re, obs_hazard, obs_wb_ex, obs_eret, obs_flush;
  logic [4:0]  obs_waddr;
  logic [31:0] obs_wdata, obs_pc;
  logic [5:0]  obs_ecode;
  logic [3:0]  obs_wen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input logic gr_we, input logic [4:0] dest,
                              input logic [31:0] result);
    ent_t e;
    e = '{pc: pc, gr_we: gr_we, dest: dest, result: result, csr_re: 1'b0, csr_we: 1'b0,
          csr_num: 14'd0, wmask: 32'd0, wvalue: 32'd0, ex: 1'b0, ecode: 6'd0, ertn: 1'b0};
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e.pc = $urandom; e.gr_we = 1'($urandom); e.dest = 5'($urandom);
    e.result = $urandom; e.csr_re = ($urandom_range(0, 3) == 0);
    e.csr_we = ($urandom_range(0, 3) == 0); e.csr_num = 14'($urandom);
    e.wmask = $urandom; e.wvalue = $urandom;
    e.ex = ($urandom_range(0, 9) == 0); e.ecode = 6'($urandom);
    e.ertn = ($urandom_range(0, 9) == 0);
    return e;
  endfunction

  // One clock cycle: drive, check against the model at negedge, advance model.
  task automatic step(input bit v, input ent_t e, input bit st, input logic [31:0] rv);
    bit ret, fl, hz, exp_rf_we, exp_csr_re, exp_csr_we, pushed;
    ent_t h;
    ms_to_ws_valid = v; ms_pc = e.pc; ms_gr_we = e.gr_we; ms_dest = e.dest;
    ms_result = e.result; ms_csr_re = e.csr_re; ms_csr_we = e.csr_we;
    ms_csr_num = e.csr_num; ms_csr_wmask = e.wmask; ms_csr_wvalue = e.wvalue;
    ms_ex = e.ex; ms_ecode = e.ecode; ms_ertn = e.ertn; ws_stall = st; csr_rvalue = rv;
    @(negedge clk);
    ret = (model_q.size() != 0) && !st;
    h = mk(32'd0, 1'b0, 5'd0, 32'd0);
    if (ret) h = model_q[0];
    fl = ret && (h.ex || h.ertn);
    hz = 1'b0;
    foreach (model_q[i]) hz |= model_q[i].csr_re;
    exp_rf_we  = ret && !h.ex && !h.ertn && (h.gr_we || h.csr_re);
    exp_csr_re = ret && !h.ex && (h.ertn || h.csr_re);
    exp_csr_we = ret && !h.ex && !h.ertn && h.csr_we;
    check("allowin", 64'(ws_allowin), 64'((model_q.size() != DEPTH) && !fl));
    check("rf_we", 64'(rf_we), 64'(exp_rf_we));
    check("rf_wen", 64'(debug_wb_rf_wen), 64'({4{exp_rf_we}}));
    check("csr_re", 64'(csr_re), 64'(exp_csr_re));
    check("csr_we", 64'(csr_we), 64'(exp_csr_we));
    check("wb_ex", 64'(wb_ex), 64'(ret && h.ex));
    check("eret", 64'(eret_flush), 64'(ret && !h.ex && h.ertn));
    check("flush", 64'(ws_flush_pipe), 64'(fl));
    check("hazard", 64'(ws_csr_hazard), 64'(hz));
    check("esub", 64'(wb_esubcode), 64'd0);
    if (exp_rf_we) begin
      check("waddr", 64'(rf_waddr), 64'(h.dest));
      check("wdata", 64'(rf_wdata), 64'(h.csr_re ? rv : h.result));
    end
    if (exp_csr_re || exp_csr_we) check("csr_num", 64'(csr_num), 64'(h.csr_num));
    if (exp_csr_we) check("csr_wr", 64'({csr_wmask, csr_wvalue}), {h.wmask, h.wvalue});
    if (ret) check("wb_pc", 64'(debug_wb_pc), 64'(h.pc));
    if (ret && h.ex) check("ecode", 64'(wb_ecode), 64'(h.ecode));
`ifdef WB_PERF_CNT_EN
    check("retire_cnt", retire_cnt, m_retire_cnt);
    check("flush_cnt", 64'(flush_cnt), 64'(m_flush_cnt));
`endif
    obs_allowin = ws_allowin; obs_rf_we = rf_we; obs_csr_re = csr_re; obs_hazard = ws_csr_hazard;
    obs_wb_ex = wb_ex; obs_eret = eret_flush; obs_flush = ws_flush_pipe; obs_waddr = rf_waddr;
    obs_wdata = rf_wdata; obs_pc = wb_pc; obs_ecode = wb_ecode; obs_wen = debug_wb_rf_wen;
    pushed = v && (model_q.size() != DEPTH) && !fl;
    @(posedge clk);
`ifdef WB_PERF_CNT_EN
    if (ret && !h.ex) m_retire_cnt++;
    if (fl) m_flush_cnt++;
`endif
    if (fl) model_q.delete();
    else begin
      if (ret) void'(model_q.pop_front());
      if (pushed) model_q.push_back(e);
    end
    $display("cyc v=%0b st=%0b ret=%0b flush=%0b qsize=%0d", v, st, ret, fl, model_q.size());
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ms_to_ws_valid = 1'b0; ws_stall = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_q.delete();
`ifdef WB_PERF_CNT_EN
    m_retire_cnt = '0; m_flush_cnt = '0;
`endif
    $display("reset applied");
  endtask

  ent_t e0, e1, e2, z;
  initial begin
    z = mk(32'd0, 1'b0, 5'd0, 32'd0);
    reset = 1'b1; ms_to_ws_valid = 1'b0; ws_stall = 1'b0; csr_rvalue = '0;
    ms_pc = '0; ms_gr_we = 0; ms_dest = '0; ms_result = '0; ms_csr_re = 0; ms_csr_we = 0;
    ms_csr_num = '0; ms_csr_wmask = '0; ms_csr_wvalue = '0; ms_ex = 0; ms_ecode = '0; ms_ertn = 0;
    @(posedge clk);
    do_reset();

    // Reset state and first single-entry writeback.
    step(1'b1, mk(32'h1c000000, 1'b1, 5'd5, 32'h12345678), 1'b0, 32'h0);
    check("reset_allowin", 64'(obs_allowin), 64'd1);
    check("reset_rf_we", 64'(obs_rf_we), 64'd0);
    step(1'b0, z, 1'b0, 32'h0);
    check("t1_rf_we", 64'(obs_rf_we), 64'd1);
    check("t1_waddr", 64'(obs_waddr), 64'd5);
    check("t1_wdata", 64'(obs_wdata), 64'h12345678);
    check("t1_wen", 64'(obs_wen), 64'hf);

    // Full queue under stall, then in-order drain.
    e0 = mk(32'h1c000100, 1'b1, 5'd1, 32'h11); e1 = mk(32'h1c000104, 1'b1, 5'd2, 32'h22);
    e2 = mk(32'h1c000108, 1'b1, 5'd3, 32'h33);
    step(1'b1, e0, 1'b1, 32'h0);
    step(1'b1, e1, 1'b1, 32'h0);
    step(1'b1, e2, 1'b1, 32'h0);
    check("full_allowin", 64'(obs_allowin), 64'd0);
    step(1'b1, e2, 1'b0, 32'h0);
    check("drain0_pc", 64'(obs_pc), 64'h1c000100);
    check("drain0_allowin", 64'(obs_allowin), 64'd0);
    step(1'b1, e2, 1'b0, 32'h0);
    check("drain1_pc", 64'(obs_pc), 64'h1c000104);
    check("drain1_allowin", 64'(obs_allowin), 64'd1);
    step(1'b0, z, 1'b0, 32'h0);
    check("drain2_pc", 64'(obs_pc), 64'h1c000108);

    // CSR read: hazard while queued, read value forwarded at retire.
    e0 = mk(32'h1c000200, 1'b0, 5'd7, 32'h0); e0.csr_re = 1'b1; e0.csr_num = 14'h5;
    step(1'b1, e0, 1'b1, 32'h0);
    step(1'b0, z, 1'b1, 32'h0);
    check("csr_hazard", 64'(obs_hazard), 64'd1);
    step(1'b0, z, 1'b0, 32'hdeadbeef);
    check("csr_re_ret", 64'(obs_csr_re), 64'd1);
    check("csr_wdata", 64'(obs_wdata), 64'hdeadbeef);

    // Exception at head flushes the queue and a same-cycle push.
    e0 = mk(32'h1c000010, 1'b1, 5'd9, 32'h99); e0.ex = 1'b1; e0.ecode = 6'h0b;
    step(1'b1, e0, 1'b1, 32'h0);
    step(1'b1, mk(32'h1c000014, 1'b1, 5'd10, 32'haa), 1'b1, 32'h0);
    step(1'b1, mk(32'h1c000018, 1'b1, 5'd11, 32'hbb), 1'b0, 32'h0);
    check("ex_wb_ex", 64'(obs_wb_ex), 64'd1);
    check("ex_ecode", 64'(obs_ecode), 64'h0b);
    check("ex_pc", 64'(obs_pc), 64'h1c000010);
    check("ex_flush", 64'(obs_flush), 64'd1);
    check("ex_rf_we", 64'(obs_rf_we), 64'd0);
    step(1'b0, z, 1'b0, 32'h0);
    check("ex_after_rf_we", 64'(obs_rf_we), 64'd0);

    // ERTN at head.
    e0 = mk(32'h1c000300, 1'b0, 5'd0, 32'h0); e0.ertn = 1'b1; e0.csr_num = 14'h6;
    step(1'b1, e0, 1'b1, 32'h0);
    step(1'b0, z, 1'b0, 32'h1c000400);
    check("ertn_eret", 64'(obs_eret), 64'd1);
    check("ertn_csr_re", 64'(obs_csr_re), 64'd1);
    check("ertn_rf_we", 64'(obs_rf_we), 64'd0);
    step(1'b0, z, 1'b0, 32'h0);
    check("ertn_after_eret", 64'(obs_eret), 64'd0);

    // Reset with a full queue.
    step(1'b1, mk(32'h1c000500, 1'b1, 5'd4, 32'h44), 1'b1, 32'h0);
    step(1'b1, mk(32'h1c000504, 1'b1, 5'd4, 32'h55), 1'b1, 32'h0);
    do_reset();
    step(1'b0, z, 1'b0, 32'h0);
    check("rst2_allowin", 64'(obs_allowin), 64'd1);
    check("rst2_rf_we", 64'(obs_rf_we), 64'd0);
    check("rst2_flush", 64'(obs_flush), 64'd0);
`ifdef WB_PERF_CNT_EN
    check("rst2_retire_cnt", retire_cnt, 64'd0);
    check("rst2_flush_cnt", 64'(flush_cnt), 64'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 9) < 7), rnd_ent(), ($urandom_range(0, 9) < 3), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
